// File: rtl/pager_pkg.sv
// pager_pkg: shared FSM state type, default timing constants and counter-width helper
//   Used by pager_scheduler and the zero-sequence pager detector.
package pager_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } pager_state_e;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_ON_CYC  = 8;
    localparam int DEF_OFF_CYC = 8;
    localparam int DEF_REPEATS = 3;
    localparam int DEF_GAP_CYC = 4;

    // bits needed to hold n-1, never less than one
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder
//   req_i    in  N      request vector
//   ptr_i    in  IW     last owner; search starts at ptr_i+1 (cyclic)
//   onehot_o out N      one-hot winner, 0 when no request
//   idx_o    out IW     winner index, 0 when no request
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         onehot_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    int i;

    // walk from farthest to nearest so the nearest set bit wins
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        i        = 0;
        for (int k = N; k >= 1; k--) begin
            i = (int'(ptr_i) + k) % N;
            if (req_i[IW'(i)]) begin
                onehot_o        = '0;
                onehot_o[IW'(i)] = 1'b1;
                idx_o           = IW'(i);
            end
        end
    end

endmodule

// File: rtl/pager_scheduler.sv
// pager_scheduler: round-robin sharing of one pager buzz output among N_REQ requesters
//   clk       in  1      system clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   req_i     in  N_REQ  level page requests
//   ack_i     in  1      user acknowledge
//   grant_o   out N_REQ  one-hot current owner, 0 when none
//   busy_o    out 1      high in ON/OFF/GAP
//   buzz_o    out 1      alert drive, high only in ON
//   done_o    out 1      one-cycle pulse when a page finishes
//   done_id_o out IDW    finished owner, valid with done_o
//   acked_o   out 1      page ended by ack (with done_o)
//   missed_o  out 1      page ended by burst expiry (with done_o)
module pager_scheduler
    import pager_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ON_CYC  = DEF_ON_CYC,
    parameter int OFF_CYC = DEF_OFF_CYC,
    parameter int REPEATS = DEF_REPEATS,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     ack_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic                     buzz_o,
    output logic                     done_o,
    output logic [$clog2(N_REQ)-1:0] done_id_o,
    output logic                     acked_o,
    output logic                     missed_o
);

    localparam int IDW  = $clog2(N_REQ);
    localparam int CMAX = ((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC) > GAP_CYC
                          ? ((ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC) : GAP_CYC;
    localparam int CW   = cnt_w(CMAX);
    localparam int RW   = cnt_w(REPEATS);

    localparam logic [CW-1:0]  ON_LD    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0]  OFF_LD   = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0]  GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [RW-1:0]  REP_LAST = RW'(REPEATS - 1);
    localparam logic [IDW-1:0] PTR_RST  = IDW'(N_REQ - 1);

    pager_state_e     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             buzz_q, buzz_d;
    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic             acked_q, acked_d;
    logic             missed_q, missed_d;
    logic [N_REQ-1:0] arb_oh;
    logic [IDW-1:0]   arb_idx;
    logic             cnt_zero, expire, end_pg;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .onehot_o (arb_oh),
        .idx_o    (arb_idx)
    );

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        acked_d  = 1'b0;
        missed_d = 1'b0;
        end_pg   = 1'b0;
        expire   = (state_q == OFF) && cnt_zero && (rep_q == REP_LAST);
        unique case (state_q)
            IDLE: if (|req_i) begin
                state_d = ON;
                owner_d = arb_idx;
                cnt_d   = ON_LD;
                rep_d   = '0;
            end
            ON, OFF: begin
                // end causes in priority order: ack, withdraw, expiry
                if (ack_i) begin
                    end_pg  = 1'b1;
                    acked_d = 1'b1;
                end else if (!req_i[owner_q]) begin
                    end_pg = 1'b1;
                end else if (expire) begin
                    end_pg   = 1'b1;
                    missed_d = 1'b1;
                end else if (cnt_zero) begin
                    state_d = (state_q == ON) ? OFF : ON;
                    cnt_d   = (state_q == ON) ? OFF_LD : ON_LD;
                    rep_d   = (state_q == ON) ? rep_q : rep_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (end_pg) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                    ptr_d   = owner_q;
                end
            end
            GAP: begin
                state_d = cnt_zero ? IDLE : GAP;
                cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        done_d    = end_pg;
        done_id_d = end_pg ? owner_q : '0;
        busy_d    = (state_d != IDLE);
        buzz_d    = (state_d == ON);
        // a fresh grant comes from the arbiter; a running page keeps its grant
        grant_d   = (state_d == ON || state_d == OFF)
                    ? ((state_q == IDLE) ? arb_oh : grant_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rep_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= PTR_RST;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            buzz_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            acked_q   <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rep_q     <= rep_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            buzz_q    <= buzz_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            acked_q   <= acked_d;
            missed_q  <= missed_d;
        end
    end

    assign grant_o   = grant_q;
    assign busy_o    = busy_q;
    assign buzz_o    = buzz_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign acked_o   = acked_q;
    assign missed_o  = missed_q;

endmodule
